// File: rtl/sssp_pkg.sv
// Shared types and constants for the sssp update packing path.
package sssp_pkg;

    localparam int unsigned UPD_W  = 64;
    localparam int unsigned LINE_W = 512;
    localparam int unsigned SLOTS  = LINE_W / UPD_W;

    // Filler record; software discards dest_vid 0xFFFFFFFF.
    localparam logic [UPD_W-1:0] PAD = {UPD_W{1'b1}};

    typedef struct packed {
        logic [31:0] dest_vid;
        logic [31:0] value;
    } upd_t;

    typedef enum logic [1:0] {
        StAccum,
        StFlush,
        StDone
    } pack_state_e;

endpackage

// File: rtl/sssp_lane_compactor.sv
// Prefix popcount over the lane valid mask: each lane's offset among this
// cycle's valid lanes, plus the total number of valid lanes.
module sssp_lane_compactor #(
    parameter int unsigned LANES = 8
) (
    input  logic [LANES-1:0]                          upd_valid,
    output logic [LANES-1:0][$clog2(LANES+1)-1:0]     lane_offset,
    output logic [$clog2(LANES+1)-1:0]                upd_k
);

    localparam int unsigned OW = $clog2(LANES + 1);

    logic [OW-1:0] acc;

    // Exclusive prefix sum; lane i lands after all lower valid lanes.
    always_comb begin
        acc         = '0;
        lane_offset = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            lane_offset[i] = acc;
            acc            = acc + OW'(upd_valid[i]);
        end
        upd_k = acc;
    end

endmodule

// File: rtl/sssp_update_packer.sv
// Compacts sparse per-lane update records into full cache lines for the AFU
// write path; pads and emits any partial line on flush.
module sssp_update_packer
    import sssp_pkg::*;
#(
    parameter int unsigned LANES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*UPD_W-1:0]  upd_in,
    input  logic [LANES-1:0]        upd_valid,
    input  logic                    flush_in,
    output logic [LINE_W-1:0]       word_out,
    output logic                    valid_out,
    output logic                    done,
    output logic [31:0]             upd_count,
    output logic [31:0]             line_count,
    output logic                    proto_err
);

    localparam int unsigned BUF_SLOTS = SLOTS + LANES - 1;
    localparam int unsigned CW        = $clog2(BUF_SLOTS + 1);
    localparam int unsigned OW        = $clog2(LANES + 1);

    if ((LINE_W % UPD_W) != 0 || SLOTS < LANES) begin : g_bad_cfg
        $error("sssp_update_packer: LINE_W must be a multiple of UPD_W and SLOTS >= LANES");
    end

    pack_state_e              state_q, state_d;
    upd_t                     buf_q [BUF_SLOTS];
    upd_t                     buf_d [BUF_SLOTS];
    upd_t                     merged [BUF_SLOTS];
    logic [CW-1:0]            count_q, count_d;
    logic [CW:0]              total;
    logic [CW:0]              tgt [LANES];
    logic [LINE_W-1:0]        word_q, word_d;
    logic                     valid_q, valid_d;
    logic [31:0]              upd_cnt_q, upd_cnt_d;
    logic [31:0]              line_cnt_q, line_cnt_d;
    logic                     err_q, err_d;
    logic [LANES-1:0][OW-1:0] lane_offset;
    logic [OW-1:0]            upd_k;

    sssp_lane_compactor #(
        .LANES (LANES)
    ) u_compactor (
        .upd_valid   (upd_valid),
        .lane_offset (lane_offset),
        .upd_k       (upd_k)
    );

    // Target buffer slot of each lane and the post-append record count.
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            tgt[i] = {1'b0, count_q} + (CW+1)'(lane_offset[i]);
        end
        total = {1'b0, count_q} + (CW+1)'(upd_k);
    end

    // Buffered records with this cycle's valid lanes appended in lane order.
    always_comb begin
        merged = buf_q;
        for (int i = 0; i < int'(LANES); i++) begin
            if (upd_valid[i] && tgt[i] < (CW+1)'(BUF_SLOTS)) begin
                merged[tgt[i][CW-1:0]] = upd_t'(upd_in[i*UPD_W +: UPD_W]);
            end
        end
    end

    // FSM next state, emit decision, buffer shift and counters.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        buf_d      = buf_q;
        word_d     = word_q;
        valid_d    = 1'b0;
        upd_cnt_d  = upd_cnt_q;
        line_cnt_d = line_cnt_q;
        err_d      = err_q;

        unique case (state_q)
            StAccum: begin
                upd_cnt_d = upd_cnt_q + 32'(upd_k);
                if (total >= (CW+1)'(SLOTS)) begin
                    valid_d    = 1'b1;
                    line_cnt_d = line_cnt_q + 32'd1;
                    for (int s = 0; s < int'(SLOTS); s++) begin
                        word_d[s*UPD_W +: UPD_W] = merged[s];
                    end
                    // Residual records move down so slot 0 stays the oldest.
                    for (int s = 0; s < int'(BUF_SLOTS - SLOTS); s++) begin
                        buf_d[s] = merged[s + int'(SLOTS)];
                    end
                    for (int s = int'(BUF_SLOTS - SLOTS); s < int'(BUF_SLOTS); s++) begin
                        buf_d[s] = '0;
                    end
                    count_d = CW'(total - (CW+1)'(SLOTS));
                end else begin
                    buf_d   = merged;
                    count_d = CW'(total);
                end
                if (flush_in) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (|upd_valid || flush_in) begin
                    err_d = 1'b1;
                end
                // count_q already reflects any line emitted on the flush cycle.
                if (count_q != '0) begin
                    valid_d    = 1'b1;
                    line_cnt_d = line_cnt_q + 32'd1;
                    for (int s = 0; s < int'(SLOTS); s++) begin
                        word_d[s*UPD_W +: UPD_W] = (s < int'(count_q)) ? buf_q[s] : PAD;
                    end
                    count_d = '0;
                end
                state_d = StDone;
            end
            StDone: begin
                if (|upd_valid || flush_in) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = StAccum;
            end
        endcase
    end

    // State, buffer, output and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StAccum;
            count_q    <= '0;
            buf_q      <= '{default: '0};
            word_q     <= '0;
            valid_q    <= 1'b0;
            upd_cnt_q  <= '0;
            line_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            buf_q      <= buf_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            upd_cnt_q  <= upd_cnt_d;
            line_cnt_q <= line_cnt_d;
            err_q      <= err_d;
        end
    end

    assign word_out   = word_q;
    assign valid_out  = valid_q;
    assign done       = (state_q == StDone);
    assign upd_count  = upd_cnt_q;
    assign line_count = line_cnt_q;
    assign proto_err  = err_q;

endmodule

// File: tb/tb_sssp_update_packer.sv
// Directed, table-driven bench for sssp_update_packer.
module tb_sssp_update_packer;
    import sssp_pkg::*;

    localparam int unsigned LANES = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [LANES*UPD_W-1:0] upd_in;
    logic [LANES-1:0]       upd_valid;
    logic                   flush_in;
    logic [LINE_W-1:0]      word_out;
    logic                   valid_out;
    logic                   done;
    logic [31:0]            upd_count;
    logic [31:0]            line_count;
    logic                   proto_err;

    int errors = 0;
    int checks = 0;

    sssp_update_packer #(
        .LANES (LANES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .upd_in     (upd_in),
        .upd_valid  (upd_valid),
        .flush_in   (flush_in),
        .word_out   (word_out),
        .valid_out  (valid_out),
        .done       (done),
        .upd_count  (upd_count),
        .line_count (line_count),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    // Slot codes: {cycle, lane} of the record; 16'hFFFF marks a PAD slot.
    localparam logic [15:0] PC = 16'hFFFF;

    typedef struct {
        logic            rst;
        logic [7:0]      vld;
        logic            flush;
        logic            exp_valid;
        logic            chk_word;
        logic [7:0][15:0] exp_slots;
        logic [31:0]     exp_upd;
        logic [31:0]     exp_line;
        logic            exp_done;
        logic            exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] rc(input int c, input int i);
        return {8'(c), 8'(i)};
    endfunction

    function automatic logic [63:0] rec(input logic [15:0] code);
        if (code == PC) return PAD;
        return {16'h0, code, 16'h0, code};
    endfunction

    function automatic logic [7:0][15:0] s8(input logic [15:0] a0, a1, a2, a3,
                                            a4, a5, a6, a7);
        logic [7:0][15:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
        return r;
    endfunction

    function automatic logic [LINE_W-1:0] line_of(input logic [7:0][15:0] sl);
        logic [LINE_W-1:0] w;
        for (int j = 0; j < 8; j++) w[j*UPD_W +: UPD_W] = rec(sl[j]);
        return w;
    endfunction

    task automatic add(input logic r, input logic [7:0] m, input logic f, input logic ev,
                       input logic cw, input logic [7:0][15:0] sl, input int eu,
                       input int el, input logic ed, input logic ee);
        vec_t v;
        v.rst = r; v.vld = m; v.flush = f; v.exp_valid = ev; v.chk_word = cw;
        v.exp_slots = sl; v.exp_upd = 32'(eu); v.exp_line = 32'(el);
        v.exp_done = ed; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [LINE_W-1:0] got,
                         input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic drive(input int c, input logic r, input logic [7:0] m, input logic f);
        rst       = r;
        upd_valid = m;
        flush_in  = f;
        for (int i = 0; i < int'(LANES); i++) upd_in[i*UPD_W +: UPD_W] = rec(rc(c, i));
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " word"},  word_out, '0);
        check({tag, " valid"}, LINE_W'(valid_out), '0);
        check({tag, " done"},  LINE_W'(done), '0);
        check({tag, " upd"},   LINE_W'(upd_count), '0);
        check({tag, " line"},  LINE_W'(line_count), '0);
        check({tag, " err"},   LINE_W'(proto_err), '0);
    endtask

    initial begin
        logic [7:0][15:0] z;
        logic [7:0][15:0] l0, l1, l2, l3, l4, l5;
        int waited;
        z  = '0;
        l0 = s8(rc(0,0), rc(0,1), rc(0,2), rc(0,3), rc(0,4), rc(0,5), rc(0,6), rc(0,7));
        l1 = s8(rc(2,1), rc(2,3), rc(3,1), rc(3,3), rc(4,1), rc(4,3), rc(5,1), rc(5,3));
        l2 = s8(rc(6,0), rc(6,1), rc(6,2), rc(6,3), rc(6,4), rc(7,0), rc(7,2), rc(7,3));
        l3 = s8(rc(7,5), rc(7,6), rc(7,7), PC, PC, PC, PC, PC);
        l4 = s8(rc(16,0), rc(16,1), rc(16,2), rc(16,3), rc(16,4), rc(17,1), rc(17,4),
                rc(17,6));
        l5 = s8(rc(24,0), rc(24,1), rc(24,2), rc(24,3), rc(24,4), rc(24,5), rc(24,6),
                rc(24,7));

        //   rst   vld           fl  ev  cw  slots upd line done err
        add(1'b0, 8'hFF,       0, 1, 1, l0,   8,  1,  0, 0);  // v0 full burst
        add(1'b0, 8'h00,       0, 0, 1, l0,   8,  1,  0, 0);  // v1 word holds
        add(1'b0, 8'b00001010, 0, 0, 0, z,   10,  1,  0, 0);  // v2..v5 lanes {1,3}
        add(1'b0, 8'b00001010, 0, 0, 0, z,   12,  1,  0, 0);
        add(1'b0, 8'b00001010, 0, 0, 0, z,   14,  1,  0, 0);
        add(1'b0, 8'b00001010, 0, 1, 1, l1,  16,  2,  0, 0);
        add(1'b0, 8'h1F,       0, 0, 0, z,   21,  2,  0, 0);  // v6 5 records
        add(1'b0, 8'b11101101, 0, 1, 1, l2,  27,  3,  0, 0);  // v7 6 records
        add(1'b0, 8'h00,       1, 0, 0, z,   27,  3,  0, 0);  // v8 flush
        add(1'b0, 8'h00,       0, 1, 1, l3,  27,  4,  1, 0);  // v9 pad line
        add(1'b0, 8'h00,       0, 0, 0, z,   27,  4,  1, 0);
        add(1'b1, 8'h00,       0, 0, 1, z,    0,  0,  0, 0);  // v11 rst
        add(1'b0, 8'h00,       1, 0, 0, z,    0,  0,  0, 0);  // v12 empty flush
        add(1'b0, 8'h00,       0, 0, 0, z,    0,  0,  1, 0);
        add(1'b0, 8'h00,       0, 0, 0, z,    0,  0,  1, 0);
        add(1'b1, 8'h00,       0, 0, 1, z,    0,  0,  0, 0);  // v15 rst
        add(1'b0, 8'h1F,       0, 0, 0, z,    5,  0,  0, 0);  // v16 residual 5
        add(1'b0, 8'b01010010, 1, 1, 1, l4,   8,  1,  0, 0);  // v17 flush + 3
        add(1'b0, 8'h00,       0, 0, 0, z,    8,  1,  1, 0);  // v18 no pad line
        add(1'b0, 8'hFF,       0, 0, 0, z,    8,  1,  1, 1);  // v19 input in DONE
        add(1'b0, 8'h00,       0, 0, 0, z,    8,  1,  1, 1);
        add(1'b1, 8'h00,       0, 0, 1, z,    0,  0,  0, 0);  // v21 rst
        add(1'b0, 8'h3F,       0, 0, 0, z,    6,  0,  0, 0);  // v22 6 buffered
        add(1'b1, 8'h00,       0, 0, 1, z,    0,  0,  0, 0);  // v23 rst discards
        add(1'b0, 8'hFF,       0, 1, 1, l5,   8,  1,  0, 0);  // v24 only new records

        // Reset state.
        drive(0, 1'b1, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");

        foreach (vecs[v]) begin
            string tag;
            tag = $sformatf("v%0d", v);
            drive(v, vecs[v].rst, vecs[v].vld, vecs[v].flush);
            @(posedge clk);
            #1;
            check({tag, " valid"}, LINE_W'(valid_out), LINE_W'(vecs[v].exp_valid));
            check({tag, " upd"},   LINE_W'(upd_count), LINE_W'(vecs[v].exp_upd));
            check({tag, " line"},  LINE_W'(line_count), LINE_W'(vecs[v].exp_line));
            check({tag, " done"},  LINE_W'(done), LINE_W'(vecs[v].exp_done));
            check({tag, " err"},   LINE_W'(proto_err), LINE_W'(vecs[v].exp_err));
            if (vecs[v].chk_word)
                check({tag, " word"}, word_out, line_of(vecs[v].exp_slots));
        end

        // Empty flush, waiting on done with a bounded budget.
        drive(40, 1'b1, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        drive(41, 1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        drive(42, 1'b0, 8'h00, 1'b0);
        waited = 1;
        while (!done && waited < 10) begin
            check("wait no valid", LINE_W'(valid_out), '0);
            @(posedge clk);
            #1;
            waited++;
        end
        check("done latency", LINE_W'(waited), LINE_W'(2));
        check("done level", LINE_W'(done), LINE_W'(1));
        check("empty flush lines", LINE_W'(line_count), '0);
        check("empty flush valid", LINE_W'(valid_out), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sssp_update_packer.md
Name: sssp_update_packer

Overview:
- Sits directly downstream of the sssp pipelines, in front of the AFU write-request path.
- Each cycle, collects sparse per-lane update records from the parallel pipelines and compacts them in arrival order.
- Packs the records into full cache lines. Each line is emitted as a one-cycle valid_out pulse, which the AFU turns straight into a write request.
- On flush, pads and emits any partial line, then signals done.

Parameters:
- LANES, 8, number of pipeline lanes feeding the packer.
- UPD_W, 64, bits per update record: {dest_vid[63:32], value[31:0]}.
- LINE_W, 512, cache-line width.
- SLOTS, LINE_W/UPD_W (8), records per line. Must be an integer and ≥ LANES; check at elaboration.
- PAD, {UPD_W{1'b1}}, filler record. Software discards dest_vid 0xFFFFFFFF.

Ports:
- clk, in, 1, single clock.
- rst, in, 1, synchronous, active-high reset.
- upd_in, in, LANES*UPD_W, lane i occupies bits [i*UPD_W +: UPD_W].
- upd_valid, in, LANES, per-lane record valid.
- flush_in, in, 1, one-cycle pulse: no more updates after this cycle.
- word_out, out, LINE_W, packed line; slot j occupies bits [j*UPD_W +: UPD_W].
- valid_out, out, 1, word_out valid, single-cycle pulse per line.
- done, out, 1, level; set after the final line is emitted, held until rst.
- upd_count, out, 32, records accepted since reset (pads excluded).
- line_count, out, 32, lines emitted since reset.
- proto_err, out, 1, sticky; set by any upd_valid bit or flush_in while not in ACCUM.

Behaviour:
- Reset values: word_out=0, valid_out=0, done=0, upd_count=0, line_count=0, proto_err=0, buffer count=0, state=ACCUM. rst mid-operation discards buffered records with no output.
- Buffer: SLOTS+LANES-1 record slots plus a count (0..SLOTS+LANES-1). Slot 0 is the oldest record.
- Compaction: valid lanes are taken in ascending lane order. Each lane's target slot = count + popcount(upd_valid[i-1:0]); k = popcount(upd_valid).
- Ordering: earlier cycles precede later ones; within a cycle, lower lanes precede higher lanes. No reordering, no drops.
- Emit rule: if count+k ≥ SLOTS, then next cycle:
  - valid_out=1;
  - word_out = the SLOTS oldest records;
  - the remaining count+k−SLOTS records shift down to slot 0;
  - line_count increments.
- Otherwise the records are appended and valid_out=0 next cycle.
- Latency: one cycle from the input that completes a line to valid_out.
- No backpressure exists. After any emit the residual is ≤ LANES−1, so the buffer cannot overflow.
- upd_count increments by k every ACCUM cycle, wrapping at 2^32. line_count also wraps at 2^32.
- FSM states:
  - ACCUM: normal packing. On flush_in, that cycle's lanes are still absorbed (emit rule applies), then go to FLUSH.
  - FLUSH (1 cycle): if count>0, emit one line with the buffered records in the low slots, PAD in the upper slots, and clear count. If count==0, nothing is emitted. Go to DONE.
  - DONE: done=1 and valid_out=0. Held until rst.
- Error handling: upd_valid or flush_in in FLUSH/DONE is ignored (records dropped, not counted) and sets proto_err.
- Flush with zero buffered records produces no padded line. done rises two cycles after flush_in.
- A flush cycle that makes count+k exactly SLOTS emits a full line next cycle (in FLUSH) with no pad line.
  - Required implementation: FLUSH must evaluate the post-emit residual, i.e. the state register update and the emit register are written in the same cycle.
- word_out holds its last value when valid_out=0.

Decomposition:
- Shared package sssp_pkg holds:
  - UPD_W, LINE_W, PAD constants;
  - typedef upd_t = struct {dest_vid[31:0], value[31:0]};
  - packer state enum {ACCUM, FLUSH, DONE}.
- One natural sub-module, sssp_lane_compactor: combinational prefix-popcount, producing per-lane target offsets and k.
- The top holds the buffer, FSM and counters.

Test Plan:
- All 8 lanes valid on one cycle with records 0x0000000N_0000000N → next cycle valid_out=1, slot j = record j, line_count=1, upd_count=8.
- Lanes {1,3} valid for 4 consecutive cycles (8 records) → exactly one line after the 4th cycle, with slot order lane1c0, lane3c0, lane1c1, …; no earlier valid_out.
- 5 records, then 6 records next cycle → one line of records 0–7, residual 3. Then flush_in → FLUSH line with slots 0–2 = records 8–10 and slots 3–7 = 0xFFFF…F; done high one cycle later; line_count=2, upd_count=11.
- flush_in with empty buffer → no valid_out; done=1 two cycles after flush; counts unchanged.
- Flush cycle carrying 3 records with residual 5 → full line, no pad line, done follows; upd_valid asserted while in DONE → proto_err=1, upd_count unchanged.
- rst asserted with 6 records buffered → all outputs zero next cycle; a following 8-record burst emits a line containing only the new records.
